arb_req_client: RTL and testbench
=================================

# arb_req_client

Requester-side agent for one port of the team's round-robin arbiter. It queues transfer jobs, raises `req`, waits for this port's `grant` bit, streams the job's beats onto the shared bus while granted, then drops `req` for one cycle so the other port can win. One instance sits on each arbiter port, and its `req`/`grant` pair connects directly to the arbiter's `req[i]`/`grant[i]`.

## Interface
- `DATA_W`, 8, bus data width
- `LEN_W`, 4, job length field width; beats per job = `job_len`+1 (1..16)
- `DEPTH`, 4, job FIFO entries (power of two, ≥2)
- `TIMEOUT`, 15, max grant-wait cycles (used only with timeout feature)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `job_valid`  in  1  job offered
- `job_ready`  out  1  FIFO not full; push when `job_valid`&&`job_ready`
- `job_len`  in  LEN_W  beats minus one
- `job_data`  in  DATA_W  base value of the job's first beat
- `req`  out  1  request to arbiter (registered)
- `grant`  in  1  this port's grant bit from arbiter
- `bus_valid`  out  1  beat present on bus this cycle
- `bus_data`  out  DATA_W  `base`+beat index, mod 2^DATA_W
- `bus_last`  out  1  final beat of job (qualified by `bus_valid`)
- `busy`  out  1  FIFO non-empty or state≠IDLE
- `err_timeout`  out  1  one-cycle pulse on job drop (feature only)

## Operation
- FIFO holds {len, data}. Push/pop in the same cycle are both honoured. No push while full. Pop occurs only on job completion or drop.
- FSM states: IDLE, REQ, XFER, REL.
  - IDLE: `req`=0. If the FIFO is non-empty → REQ.
  - REQ: `req`=1. A sampled `grant`=1 → XFER with beat counter=0.
  - XFER: `req`=1. `bus_valid`=`grant` (combinational). `bus_data`=head.data+cnt. `bus_last`=`bus_valid`&&(cnt==head.len). The counter increments on each edge with `grant`=1. On the last beat edge, pop the FIFO → REL.
  - REL: `req`=0 for exactly one cycle. Then → REQ if the FIFO is non-empty, else → IDLE.
- `grant` low during XFER stalls the transfer: no beat is issued, the counter holds, and `req` stays 1. The job is never abandoned mid-transfer.
- `grant` is ignored in IDLE and REL. No beats are issued outside XFER.
- The counter width is LEN_W. The maximum length (all ones) gives 2^LEN_W beats with no counter overflow.
- Data wrap: base 8'hFE with len 3 gives FE, FF, 00, 01.

## Timing
- Reset values: `req`=0, `bus_valid`=0, `bus_data`=0, `bus_last`=0, `busy`=0, `err_timeout`=0, `job_ready`=1. FIFO is flushed and state is IDLE.
- Reset mid-operation: the current and queued jobs are discarded, and `req` is 0 from the next cycle.
- Latency: push at edge k into an empty, idle block gives `req`=1 after edge k+1. With `grant`=1 sampled at edge k+2, the first beat is in the cycle after k+2.
- An N-beat job with continuous grant holds `req` for N+1 cycles (REQ + N XFER). It is followed by exactly 1 REL cycle with `req`=0.
- `job_ready` is derived from the registered FIFO count. A pop does not free a slot for a push in the same cycle.

## Configuration
- `ARB_REQ_CLIENT_TIMEOUT_EN` defined:
  - A counter runs in REQ and resets on entry.
  - When it reaches TIMEOUT with `grant` still 0, `err_timeout` pulses for 1 cycle, the head job is popped without beats, and the FSM goes to REL.
  - The timeout never applies in XFER.
- Not defined: REQ waits indefinitely, `err_timeout` is tied to 0, and no counter logic exists.

## Test plan
- Single job len=2, data=8'h10, `grant` tied 1 → `req` rises 1 cycle after push. Bus shows 10, 11, 12 with `bus_last` on 12. `req`=0 for one cycle, then IDLE with `busy`=0.
- Two back-to-back jobs (len 0 data 8'hA0; len 1 data 8'hB0), `grant`=1 → beats A0(last), REL, REQ, B0, B1(last). Exactly one `req`-low cycle between jobs.
- Grant toggled 1,0,0,1,1 in XFER, job len=2, data 8'h20 → beats 20 then stall 2 cycles with `bus_valid`=0 and `req`=1, then 21, 22(last).
- Push 4 jobs with `grant`=0 → `job_ready`=0 after the 4th. A 5th `job_valid` is not accepted. Raising `grant` drains all 4 in order.
- Reset asserted on beat 2 of len=5 job → next cycle `req`=0, `bus_valid`=0, `busy`=0, `job_ready`=1. No further beats.
- With `ARB_REQ_CLIENT_TIMEOUT_EN`, `grant`=0 for 20 cycles → `err_timeout` single pulse after 15 REQ cycles, job dropped, no beats. Without the macro, `req` stays 1 and `err_timeout`=0.

Source files
------------

// File: rtl/arb_req_client.sv
// Requester agent for one round-robin arbiter port: queues jobs, requests, streams beats while granted.
// Optional grant-wait timeout is enabled by defining ARB_REQ_CLIENT_TIMEOUT_EN.
module arb_req_client #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [LEN_W-1:0]  job_len,
  input  logic [DATA_W-1:0] job_data,
  output logic              req,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              busy,
  output logic              err_timeout
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0]  len_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic [LEN_W-1:0]  head_len;
  logic [DATA_W-1:0] head_data;
  logic              push, pop;
  logic              fifo_empty;
  logic              timeout_hit;

  // Handshakes: a job is pushed on any edge where job_valid && job_ready; a beat
  // is transferred on any edge where bus_valid is high (bus_valid mirrors grant in XFER).
  assign job_ready  = (count != (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = job_valid && job_ready;
  assign head_len   = len_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign req        = (state == REQ) || (state == XFER);
  assign busy       = !fifo_empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      len_mem[wr_ptr]  <= job_len;
      data_mem[wr_ptr] <= job_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    bus_valid = 1'b0;
    bus_data  = '0;
    bus_last  = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) state_nxt = REQ;
      REQ: begin
        if (grant) begin
          state_nxt = XFER;
          cnt_nxt   = '0;
        end else if (timeout_hit) begin
          pop       = 1'b1;
          state_nxt = REL;
        end
      end
      XFER: begin
        // A low grant stalls here: no beat, counter holds, job stays at the head.
        bus_valid = grant;
        bus_data  = head_data + DATA_W'(cnt);
        bus_last  = grant && (cnt == head_len);
        if (grant) cnt_nxt = cnt + 1'b1;
        if (bus_last) begin
          pop       = 1'b1;
          state_nxt = REL;
        end
      end
      REL: state_nxt = fifo_empty ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  // tcnt is zero on every entry to REQ because it clears whenever state is not REQ.
  assign timeout_hit = (state == REQ) && !grant && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state != REQ) tcnt <= '0;
    else                     tcnt <= tcnt + 1'b1;
    if (rst) err_timeout <= 1'b0;
    else     err_timeout <= timeout_hit;
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_client.sv
// Directed bench for arb_req_client: expected beats go into a queue, a negedge monitor checks bus output.
module tb_arb_req_client;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              job_valid;
  logic              job_ready;
  logic [LEN_W-1:0]  job_len;
  logic [DATA_W-1:0] job_data;
  logic              req;
  logic              grant;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              busy;
  logic              err_timeout;

  int checks = 0;
  int errors = 0;
  logic [DATA_W:0] exp_q[$];

  arb_req_client #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_len(job_len), .job_data(job_data), .req(req), .grant(grant),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic push_job(input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] data,
                          input bit expect_beats);
    logic [DATA_W-1:0] d;
    job_valid = 1'b1;
    job_len   = len;
    job_data  = data;
    check("job_ready_at_push", job_ready, 1);
    tick();
    job_valid = 1'b0;
    if (expect_beats) begin
      for (int b = 0; b <= int'(len); b++) begin
        d = data + DATA_W'(b);
        exp_q.push_back({(b == int'(len)), d});
      end
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got data %0h last %0b expected no beat", bus_data, bus_last);
      end else begin
        check("beat", {bus_last, bus_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic exp_req [8];
    logic g_seq [5];
    int pulses;
    int pulse_at;
    exp_req = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    g_seq   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; job_valid = 1'b0; job_len = '0; job_data = '0; grant = 1'b0;
    repeat (3) tick();
    check("rst_req", req, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_bus_data", bus_data, 0);
    check("rst_bus_last", bus_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_job_ready", job_ready, 1);
    rst = 1'b0;
    tick();

    // single job, grant tied high
    grant = 1'b1;
    push_job(4'd2, 8'h10, 1'b1);
    check("t1_req_same_cycle", req, 0);
    check("t1_busy_after_push", busy, 1);
    tick();
    check("t1_req_rise", req, 1);
    check("t1_no_beat_in_req", bus_valid, 0);
    repeat (3) tick();
    tick();
    check("t1_rel_req", req, 0);
    check("t1_rel_busy", busy, 1);
    tick();
    check("t1_idle_req", req, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // back-to-back jobs: exactly one req-low cycle between them
    push_job(4'd0, 8'hA0, 1'b1);
    push_job(4'd1, 8'hB0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("t2_req_seq", req, exp_req[i]);
      tick();
    end
    check("t2_busy", busy, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // grant stall inside XFER
    push_job(4'd2, 8'h20, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      grant = g_seq[i];
      #1;
      check("t3_req_stall", req, 1);
      check("t3_bus_valid", bus_valid, g_seq[i]);
      tick();
    end
    grant = 1'b1;
    check("t3_rel_req", req, 0);
    tick();
    check("t3_queue_empty", exp_q.size(), 0);

    // fill FIFO with grant low, reject a 5th job, then drain in order
    grant = 1'b0;
    push_job(4'd0,  8'hC0, 1'b1);
    push_job(4'd3,  8'hFE, 1'b1);
    push_job(4'd15, 8'hF8, 1'b1);
    push_job(4'd1,  8'hE0, 1'b1);
    check("t4_full_job_ready", job_ready, 0);
    check("t4_req_waiting", req, 1);
    job_valid = 1'b1; job_len = 4'd0; job_data = 8'h99;
    tick();
    job_valid = 1'b0;
    check("t4_still_full", job_ready, 0);
    check("t4_no_beat_without_grant", bus_valid, 0);
    grant = 1'b1;
    wait_drain(200, "t4_drain_timeout");
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_ready_after_drain", job_ready, 1);

    // reset during beat 2 of a 6-beat job
    push_job(4'd5, 8'h40, 1'b0);
    exp_q.push_back({1'b0, 8'h40});
    exp_q.push_back({1'b0, 8'h41});
    exp_q.push_back({1'b0, 8'h42});
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("t5_req", req, 0);
    check("t5_bus_valid", bus_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_job_ready", job_ready, 1);
    rst = 1'b0;
    repeat (5) tick();
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_busy_later", busy, 0);

    // grant held low for 20 cycles
    grant = 1'b0;
    pulses = 0;
    pulse_at = 0;
`ifdef ARB_REQ_CLIENT_TIMEOUT_EN
    push_job(4'd0, 8'h60, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (err_timeout) begin
        pulses++;
        pulse_at = i;
      end
    end
    check("t6_pulse_count", pulses, 1);
    check("t6_pulse_cycle", pulse_at, TIMEOUT + 1);
    check("t6_req_after_drop", req, 0);
    check("t6_busy_after_drop", busy, 0);
`else
    push_job(4'd0, 8'h60, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (err_timeout) pulses++;
      check("t6_req_held", req, 1);
    end
    check("t6_no_err", pulses, 0);
    grant = 1'b1;
    wait_drain(50, "t6_drain_timeout");
`endif
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
